// File: rtl/icache_set_assoc.sv
// N-way set-associative instruction cache with lookup, block refill, round-robin replacement
// and invalidate-all sequencing. Defining ICACHE_PERF_CNT_EN adds hit_count/miss_count outputs.
module icache_set_assoc #(
    parameter int OFFSET_WIDTH = 2,
    parameter int LINE_WIDTH   = 6,
    parameter int WAYS         = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_instruction,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        invalidate_all,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    output logic        flush_busy
);
    localparam int TAG_WIDTH = 32 - OFFSET_WIDTH - LINE_WIDTH - 2;
    localparam int BLOCK     = 1 << OFFSET_WIDTH;
    localparam int SETS      = 1 << LINE_WIDTH;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESPOND, FLUSH} state_t;

    state_t                  state, state_next;
    logic [31:2]             addr_q;
    logic [WAY_W-1:0]        victim;
    logic [OFFSET_WIDTH-1:0] beat;
    logic [LINE_WIDTH-1:0]   flush_idx;
    logic                    flush_pend;
    logic [31:0]             resp_data;
    logic [SETS-1:0]         valid [WAYS];
    logic [WAY_W-1:0]        rr [SETS];
    logic [TAG_WIDTH-1:0]    tag_mem [WAYS][SETS];
    logic [31:0]             data_mem [WAYS][SETS*BLOCK];

    logic [LINE_WIDTH-1:0]   idx;
    logic [OFFSET_WIDTH-1:0] word;
    logic [TAG_WIDTH-1:0]    tag;
    logic                    hit, has_invalid;
    logic [WAY_W-1:0]        hit_way, free_way;
    logic                    unused_addr_bits;

    assign idx  = addr_q[LINE_WIDTH+OFFSET_WIDTH+1:OFFSET_WIDTH+2];
    assign word = addr_q[OFFSET_WIDTH+1:2];
    assign tag  = addr_q[31:32-TAG_WIDTH];
    assign unused_addr_bits = ^req_addr[1:0];

    // Hit way, and lowest-index invalid way as the preferred victim
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        has_invalid = 1'b0;
        free_way    = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[w][idx] && tag_mem[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!has_invalid && !valid[w][idx]) begin
                has_invalid = 1'b1;
                free_way    = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (flush_pend || invalidate_all) state_next = FLUSH;
                         else if (req_valid)              state_next = LOOKUP;
            LOOKUP:      state_next = hit ? RESPOND : REFILL_REQ;
            REFILL_REQ:  if (mem_req_ready) state_next = REFILL_WAIT;
            REFILL_WAIT: if (mem_resp_valid && (&beat)) state_next = RESPOND;
            RESPOND:     if (resp_ready) state_next = IDLE;
            FLUSH:       if (&flush_idx) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    assign req_ready        = reset && (state == IDLE) && !flush_pend && !invalidate_all;
    assign resp_valid       = (state == RESPOND);
    assign resp_instruction = resp_data;
    assign mem_req_valid    = (state == REFILL_REQ);
    assign mem_req_addr     = {addr_q[31:OFFSET_WIDTH+2], {(OFFSET_WIDTH+2){1'b0}}};
    assign flush_busy       = (state == FLUSH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            victim     <= '0;
            beat       <= '0;
            flush_idx  <= '0;
            flush_pend <= 1'b0;
            resp_data  <= '0;
            for (int unsigned w = 0; w < WAYS; w++) valid[w] <= '0;
            for (int unsigned s = 0; s < SETS; s++) rr[s] <= '0;
        end else begin
            state <= state_next;
            // A pulse arriving mid-transaction waits for the next IDLE; during FLUSH it is absorbed
            if (invalidate_all && state != IDLE && state != FLUSH) flush_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush_pend || invalidate_all) begin
                        flush_pend <= 1'b0;
                        flush_idx  <= '0;
                    end else if (req_valid) begin
                        addr_q <= req_addr[31:2];
                    end
                end
                LOOKUP: begin
                    if (hit) resp_data <= data_mem[hit_way][{idx, word}];
                    else     victim    <= has_invalid ? free_way : rr[idx];
                end
                REFILL_REQ: beat <= '0;
                REFILL_WAIT: begin
                    if (mem_resp_valid) begin
                        beat <= beat + 1'b1;
                        if (beat == word) resp_data <= mem_resp_data;
                        if (&beat) begin
                            valid[victim][idx] <= 1'b1;
                            if (WAYS > 1) rr[idx] <= rr[idx] + WAY_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    for (int unsigned w = 0; w < WAYS; w++) valid[w][flush_idx] <= 1'b0;
                    flush_idx <= flush_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == REFILL_WAIT && mem_resp_valid) begin
            data_mem[victim][{idx, beat}] <= mem_resp_data;
            if (&beat) tag_mem[victim][idx] <= tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit) hit_count  <= hit_count + 1'b1;
            else     miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_set_assoc.sv
// Randomized bench for icache_set_assoc against a set/way/round-robin reference model
// and a function-defined backing memory.
module tb_icache_set_assoc;
    localparam int SETS  = 64;
    localparam int WAYS  = 2;
    localparam int BLOCK = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_instruction;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        invalidate_all = 1'b0;
    logic        flush_busy;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_set_assoc #(.OFFSET_WIDTH(2), .LINE_WIDTH(6), .WAYS(WAYS)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instruction(resp_instruction),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .invalidate_all(invalidate_all),
`ifdef ICACHE_PERF_CNT_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .flush_busy(flush_busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Backing memory: each word's content is a fixed function of its address
    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Reference cache: which block tags live in which way of each set
    int unsigned m_tag [WAYS][SETS];
    bit          m_val [WAYS][SETS];
    int unsigned m_rr  [SETS];
    int unsigned m_hits = 0, m_misses = 0;

    task automatic model_clear_valid();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) m_val[w][s] = 0;
    endtask

    task automatic model_reset();
        model_clear_valid();
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_access(input logic [31:0] a, output bit hit);
        int unsigned s, t;
        int v;
        s = (a / 16) % SETS;
        t = a / 1024;
        hit = 0;
        for (int w = 0; w < WAYS; w++)
            if (m_val[w][s] && m_tag[w][s] == t) hit = 1;
        if (hit) begin
            m_hits++;
        end else begin
            m_misses++;
            v = -1;
            for (int w = 0; w < WAYS; w++)
                if (v < 0 && !m_val[w][s]) v = w;
            if (v < 0) v = int'(m_rr[s]);
            m_val[v][s] = 1;
            m_tag[v][s] = t;
            m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
    endtask

    // Starts at the first flush cycle; counts cycles flush_busy stays high
    task automatic count_flush();
        int unsigned n = 0;
        while (flush_busy && n < 200) begin
            if (req_ready) check("flush_req_ready", req_ready, 1'b0);
            n++;
            @(negedge clock);
        end
        check("flush_cycles", n, SETS);
        model_clear_valid();
    endtask

    task automatic accept_req(input logic [31:0] a);
        int unsigned n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("req_ready", req_ready, 1'b1);
        @(negedge clock);
        req_valid = 1'b0;
        req_addr  = $urandom;
    endtask

    task automatic txn(input logic [31:0] a, input bit inv_req, input int unsigned rstall,
                       input int unsigned mstall);
        bit hit, inv;
        logic [31:0] exp, base;
        model_access(a, hit);
        inv  = inv_req && !hit;
        exp  = memword({a[31:2], 2'b00});
        base = {a[31:4], 4'b0000};
        accept_req(a);
        check("lookup_resp_valid", resp_valid, 1'b0);
        @(negedge clock);
        if (hit) begin
            check("hit_resp_valid", resp_valid, 1'b1);
            check("hit_no_mem_req", mem_req_valid, 1'b0);
        end else begin
            check("miss_mem_req", mem_req_valid, 1'b1);
            check("mem_req_addr", mem_req_addr, base);
            for (int unsigned i = 0; i < mstall; i++) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'hDEAD_BEEF;
                @(negedge clock);
                mem_resp_valid = 1'b0;
                check("mem_req_hold_valid", mem_req_valid, 1'b1);
                check("mem_req_hold_addr", mem_req_addr, base);
            end
            mem_req_ready = 1'b1;
            @(negedge clock);
            mem_req_ready = 1'b0;
            check("mem_req_drop", mem_req_valid, 1'b0);
            for (int k = 0; k < BLOCK; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
                mem_resp_valid = 1'b1;
                mem_resp_data  = memword(base + 32'(4 * k));
                if (inv && k == 1) invalidate_all = 1'b1;
                @(negedge clock);
                mem_resp_valid = 1'b0;
                invalidate_all = 1'b0;
            end
            check("refill_resp_valid", resp_valid, 1'b1);
        end
        check("resp_data", resp_instruction, exp);
        for (int unsigned r = 0; r < rstall; r++) begin
            @(negedge clock);
            check("resp_hold_valid", resp_valid, 1'b1);
            check("resp_hold_data", resp_instruction, exp);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        check("resp_done", resp_valid, 1'b0);
        if (inv) begin
            check("pending_flush_ready", req_ready, 1'b0);
            @(negedge clock);
            count_flush();
        end
    endtask

    task automatic idle_invalidate();
        invalidate_all = 1'b1;
        #1;
        check("inv_idle_ready", req_ready, 1'b0);
        @(negedge clock);
        invalidate_all = 1'b0;
        count_flush();
    endtask

    initial begin
        logic [31:0] a;
        model_reset();
        #2;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_flush_busy", flush_busy, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("post_rst_ready", req_ready, 1'b1);
        @(negedge clock);

        // Cold miss, hit, replacement within one set, invalidate during refill
        txn(32'h0000_1004, 0, 0, 0);
        txn(32'h0000_1004, 0, 5, 0);
        txn(32'h0000_1000, 0, 0, 3);
        txn(32'h0000_2000, 0, 0, 0);
        txn(32'h0000_3000, 0, 0, 0);
        txn(32'h0000_2000, 0, 0, 0);
        txn(32'h0000_1000, 0, 0, 0);
        txn(32'h0000_5004, 1, 0, 0);
        txn(32'h0000_1004, 0, 0, 0);
        idle_invalidate();

        // Async reset in the middle of a refill
        accept_req(32'h0000_7008);
        @(negedge clock);
        check("mid_rst_mem_req", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hBAD0_0000 + 32'(k);
            @(negedge clock);
        end
        mem_resp_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("abort_resp_valid", resp_valid, 1'b0);
        check("abort_mem_req_valid", mem_req_valid, 1'b0);
        check("abort_flush_busy", flush_busy, 1'b0);
        check("abort_req_ready", req_ready, 1'b0);
        check("abort_resp_data", resp_instruction, 32'h0);
        model_reset();
`ifdef ICACHE_PERF_CNT_EN
        check("abort_hit_count", hit_count, 32'h0);
        check("abort_miss_count", miss_count, 32'h0);
`endif
        @(negedge clock);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_0002;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        mem_resp_data  = 32'hBAD0_0003;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        txn(32'h0000_7008, 0, 1, 0);
        txn(32'h0000_7008, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            a = (32'($urandom_range(1, 6)) << 12) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) idle_invalidate();
            txn(a, $urandom_range(0, 19) == 0, $urandom_range(0, 3), $urandom_range(0, 2));
        end

`ifdef ICACHE_PERF_CNT_EN
        check("hit_count", hit_count, 32'(m_hits));
        check("miss_count", miss_count, 32'(m_misses));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
